// File: rtl/bp_me_pkg.sv
// Shared memory-engine types and width helpers for the wormhole mem_cmd path.
`ifndef BSG_CDIV
`define BSG_CDIV(x, y) (((x) + (y) - 1) / (y))
`endif
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif
`ifndef BP_MEM_WORMHOLE_PACKET_WIDTH
`define BP_MEM_WORMHOLE_PACKET_WIDTH 620
`endif

package bp_me_pkg;

    typedef enum logic [0:0] {
        e_idle = 1'b0,
        e_send = 1'b1
    } bp_me_wh_tx_state_e;

endpackage

// File: rtl/bp_me_wormhole_flit_counter.sv
// Flit index counter shared by the wormhole flit transmitter and receive-side assembler.
module bp_me_wormhole_flit_counter #(
    parameter int cnt_width_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clear_i,
    input  logic                   up_i,
    input  logic [cnt_width_p-1:0] last_cnt_i,
    output logic [cnt_width_p-1:0] cnt_o,
    output logic                   last_o
);

    logic [cnt_width_p-1:0] r_cnt;
    logic [cnt_width_p-1:0] r_last;

    // Saturates at the loaded last index so the count never wraps inside a packet.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt  <= '0;
            r_last <= '0;
        end else if (clear_i) begin
            r_cnt  <= '0;
            r_last <= last_cnt_i;
        end else if (up_i && !last_o) begin
            r_cnt <= r_cnt + cnt_width_p'(1);
        end
    end

    assign cnt_o  = r_cnt;
    assign last_o = (r_cnt == r_last);

endmodule

// File: rtl/bp_me_wormhole_mem_cmd_flit_tx.sv
// Serializes one mem_cmd wormhole packet into len+1 flits, lowest flit first.
// Define BP_ME_WH_TX_STATS_EN to build the packet/flit statistics counters.
`ifndef BSG_CDIV
`define BSG_CDIV(x, y) (((x) + (y) - 1) / (y))
`endif
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif
`ifndef BP_MEM_WORMHOLE_PACKET_WIDTH
`define BP_MEM_WORMHOLE_PACKET_WIDTH 620
`endif

module bp_me_wormhole_mem_cmd_flit_tx
    import bp_me_pkg::*;
#(
    parameter int flit_width_p   = 64,
    parameter int cord_width_p   = 7,
    parameter int len_width_p    = 4,
    parameter int packet_width_p = `BP_MEM_WORMHOLE_PACKET_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [packet_width_p-1:0] packet_i,
    input  logic                      packet_v_i,
    output logic                      packet_ready_o,
    output logic [flit_width_p-1:0]   link_data_o,
    output logic                      link_v_o,
    input  logic                      link_ready_i,
    output logic                      len_err_o,
    output logic [31:0]               packet_count_o,
    output logic [31:0]               flit_count_o
);

    localparam int max_flits_lp = `BSG_CDIV(packet_width_p, flit_width_p);
    localparam int max_len_lp   = max_flits_lp - 1;
    localparam int cnt_width_lp = `BSG_SAFE_CLOG2(max_flits_lp);
    localparam int pad_width_lp = max_flits_lp * flit_width_p;

    bp_me_wh_tx_state_e r_state, w_state_n;

    logic [max_flits_lp-1:0][flit_width_p-1:0] r_pkt;
    logic [pad_width_lp-1:0]                   w_pkt_pad;
    logic [len_width_p-1:0]                    w_len;
    logic [cnt_width_lp-1:0]                   w_last_cnt;
    logic [cnt_width_lp-1:0]                   w_flit_cnt;
    logic                                      w_accept;
    logic                                      w_flit_hs;
    logic                                      w_last_flit;
    logic                                      w_len_over;
    logic                                      r_len_err;

    assign w_accept   = packet_v_i & packet_ready_o;
    assign w_len      = packet_i[cord_width_p +: len_width_p];
    assign w_len_over = (32'(w_len) > max_len_lp);
    assign w_last_cnt = cnt_width_lp'(w_len_over ? max_len_lp : 32'(w_len));

    always_comb begin
        w_pkt_pad = '0;
        w_pkt_pad[packet_width_p-1:0] = packet_i;
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) r_pkt <= w_pkt_pad;
    end

    bp_me_wormhole_flit_counter #(
        .cnt_width_p(cnt_width_lp)
    ) u_flit_counter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (w_accept),
        .up_i       (w_flit_hs),
        .last_cnt_i (w_last_cnt),
        .cnt_o      (w_flit_cnt),
        .last_o     (w_last_flit)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= e_idle;
        else         r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            e_idle:  if (packet_v_i) w_state_n = e_send;
            e_send:  if (link_ready_i && w_last_flit) w_state_n = e_idle;
            default: w_state_n = e_idle;
        endcase
    end

    // Ready is a pure state decode, so it never depends on link_ready_i.
    always_comb begin
        packet_ready_o = (r_state == e_idle);
        link_v_o       = (r_state == e_send);
        link_data_o    = link_v_o ? r_pkt[w_flit_cnt] : '0;
        w_flit_hs      = link_v_o & link_ready_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                     r_len_err <= 1'b0;
        else if (w_accept && w_len_over) r_len_err <= 1'b1;
    end

    assign len_err_o = r_len_err;

`ifdef BP_ME_WH_TX_STATS_EN
    logic [31:0] r_packet_count;
    logic [31:0] r_flit_count;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_packet_count <= '0;
            r_flit_count   <= '0;
        end else if (w_flit_hs) begin
            r_flit_count <= r_flit_count + 32'd1;
            if (w_last_flit) r_packet_count <= r_packet_count + 32'd1;
        end
    end

    assign packet_count_o = r_packet_count;
    assign flit_count_o   = r_flit_count;
`else
    assign packet_count_o = 32'b0;
    assign flit_count_o   = 32'b0;
`endif

endmodule

// File: tb/tb_bp_me_wormhole_mem_cmd_flit_tx.sv
// Directed plus randomized bench for the mem_cmd flit transmitter (64-bit flits, 620-bit packets).
module tb_bp_me_wormhole_mem_cmd_flit_tx;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [619:0] packet_i;
    logic         packet_v_i;
    logic         packet_ready_o;
    logic [63:0]  link_data_o;
    logic         link_v_o;
    logic         link_ready_i;
    logic         len_err_o;
    logic [31:0]  packet_count_o;
    logic [31:0]  flit_count_o;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_pkts  = '0;
    logic [31:0] exp_flits = '0;
    logic        exp_len_err = 1'b0;

    bp_me_wormhole_mem_cmd_flit_tx #(
        .flit_width_p   (64),
        .cord_width_p   (7),
        .len_width_p    (4),
        .packet_width_p (620)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .packet_i       (packet_i),
        .packet_v_i     (packet_v_i),
        .packet_ready_o (packet_ready_o),
        .link_data_o    (link_data_o),
        .link_v_o       (link_v_o),
        .link_ready_i   (link_ready_i),
        .len_err_o      (len_err_o),
        .packet_count_o (packet_count_o),
        .flit_count_o   (flit_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [619:0] rand_pkt(input int len);
        logic [639:0] p;
        for (int i = 0; i < 20; i++) p[i*32 +: 32] = $urandom;
        p[7 +: 4] = len[3:0];
        return p[619:0];
    endfunction

    task automatic check_counts(input string tag);
`ifdef BP_ME_WH_TX_STATS_EN
        check({tag, "_pkts"}, 64'(packet_count_o), 64'(exp_pkts));
        check({tag, "_flits"}, 64'(flit_count_o), 64'(exp_flits));
`else
        check({tag, "_pkts"}, 64'(packet_count_o), 64'd0);
        check({tag, "_flits"}, 64'(flit_count_o), 64'd0);
`endif
    endtask

    // mode 0: ready always high, 1: ready 1,0,1,0..., 2: random ready
    task automatic send(input logic [619:0] pkt, input int mode, input bit hold_v);
        logic [639:0] pad;
        int len, n, idx, cyc;
        bit rdy;
        pad = {20'b0, pkt};
        len = int'(pkt[7 +: 4]);
        n   = ((len > 9) ? 9 : len) + 1;
        @(negedge clk);
        check("idle_ready", 64'(packet_ready_o), 64'd1);
        check("idle_valid", 64'(link_v_o), 64'd0);
        check("len_err_pre", 64'(len_err_o), 64'(exp_len_err));
        packet_i     = pkt;
        packet_v_i   = 1'b1;
        link_ready_i = 1'($urandom_range(0, 1));
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 200) begin
            @(negedge clk);
            if (cyc == 0) begin
                exp_len_err = exp_len_err | (len > 9);
                check("len_err", 64'(len_err_o), 64'(exp_len_err));
            end
            if (hold_v) packet_i = ~pkt;
            else        packet_v_i = 1'b0;
            check("link_v", 64'(link_v_o), 64'd1);
            check("busy_ready", 64'(packet_ready_o), 64'd0);
            check($sformatf("flit%0d", idx), link_data_o, pad[idx*64 +: 64]);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            link_ready_i = rdy;
            if (rdy) idx++;
            cyc++;
        end
        check("flits_sent", 64'(idx), 64'(n));
        exp_pkts  = exp_pkts + 32'd1;
        exp_flits = exp_flits + 32'(n);
    endtask

    initial begin
        logic [619:0] p;
        reset_i      = 1'b1;
        packet_i     = '0;
        packet_v_i   = 1'b0;
        link_ready_i = 1'b0;
        #1;
        check("rst_ready", 64'(packet_ready_o), 64'd1);
        check("rst_valid", 64'(link_v_o), 64'd0);
        check("rst_data", link_data_o, 64'd0);
        check("rst_len_err", 64'(len_err_o), 64'd0);
        check_counts("rst");
        repeat (2) @(negedge clk);
        reset_i = 1'b0;

        // 1: two-flit uncached read at full rate
        send(rand_pkt(1), 0, 1'b0);
        // 2: ten-flit write with alternating ready; top flit padded with zeros
        send(rand_pkt(9), 1, 1'b0);
        @(negedge clk);
        packet_v_i = 1'b0;
        check("t2_idle_after", 64'(packet_ready_o), 64'd1);
        check_counts("t2");
        // 3: back-to-back header-only packets with valid held through e_send
        send(rand_pkt(0), 0, 1'b1);
        send(rand_pkt(0), 0, 1'b1);
        @(negedge clk);
        packet_v_i = 1'b0;
        check("t3_idle_after", 64'(packet_ready_o), 64'd1);
        // 4: oversize len is clamped and flagged; flag stays set
        send(rand_pkt(15), 0, 1'b0);
        send(rand_pkt(2), 2, 1'b0);

        // 5: reset in the middle of a ten-flit packet
        @(negedge clk);
        packet_i     = rand_pkt(9);
        packet_v_i   = 1'b1;
        link_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            packet_v_i = 1'b0;
            check($sformatf("t5_flit%0d", i), link_data_o, 64'(packet_i >> (i * 64)));
        end
        #2 reset_i = 1'b1;
        #1;
        check("t5_rst_valid", 64'(link_v_o), 64'd0);
        check("t5_rst_ready", 64'(packet_ready_o), 64'd1);
        check("t5_rst_len_err", 64'(len_err_o), 64'd0);
        exp_pkts    = '0;
        exp_flits   = '0;
        exp_len_err = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_stale_v", 64'(link_v_o), 64'd0);
            check("t5_ready", 64'(packet_ready_o), 64'd1);
        end
        check_counts("t5");

`ifdef BP_ME_WH_TX_STATS_EN
        // 6: counters wrap modulo 2^32
        @(negedge clk);
        force dut.r_packet_count = 32'hFFFF_FFFF;
        force dut.r_flit_count   = 32'hFFFF_FFFE;
        #1;
        release dut.r_packet_count;
        release dut.r_flit_count;
        exp_pkts  = 32'hFFFF_FFFF;
        exp_flits = 32'hFFFF_FFFE;
        send(rand_pkt(1), 0, 1'b0);
        @(negedge clk);
        check_counts("t6_wrap");
`endif

        // random packets, lengths and backpressure
        for (int k = 0; k < 20; k++) begin
            p = rand_pkt(int'($urandom_range(0, 15)));
            send(p, 2, 1'b0);
        end
        @(negedge clk);
        packet_v_i   = 1'b0;
        link_ready_i = 1'b0;
        @(negedge clk);
        check("end_idle", 64'(link_v_o), 64'd0);
        check_counts("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
